// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared encodings and constants for the LED sequencer
package led_seq_pkg;
    localparam logic [1:0] MODE_DIRECT = 2'd0;
    localparam logic [1:0] MODE_BLINK  = 2'd1;
    localparam logic [1:0] MODE_ROTL   = 2'd2;
    localparam logic [1:0] MODE_ROTR   = 2'd3;

    localparam logic [1:0] ADDR_PATTERN = 2'd0;
    localparam logic [1:0] ADDR_MODE    = 2'd1;
    localparam logic [1:0] ADDR_DIV     = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    localparam logic [15:0] RST_PATTERN = 16'h55aa;

    typedef enum logic [1:0] {
        S_DIRECT    = 2'd0,
        S_BLINK_ON  = 2'd1,
        S_BLINK_OFF = 2'd2,
        S_ROTATE    = 2'd3
    } state_t;

    // State a mode starts in after a MODE or PATTERN write.
    function automatic state_t entry_state(input logic [1:0] m);
        return m == MODE_DIRECT ? S_DIRECT : m == MODE_BLINK ? S_BLINK_ON : S_ROTATE;
    endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: one-cycle tick every div cycles, restartable by clear
//   clk, rst (async active-low), div (cycles per tick), clear (restart count),
//   tick (one-cycle pulse; never asserted while clear is high)
module tick_prescaler #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div,
    input  logic             clear,
    output logic             tick
);
    logic [DIV_W-1:0] cnt;

    // div of 0 or 1 both mean every cycle; div >= 2 keeps div-1 from wrapping.
    assign tick = !clear && (div <= DIV_W'(1) || cnt == div - DIV_W'(1));

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            cnt <= '0;
        else
            cnt <= (clear || tick) ? '0 : cnt + DIV_W'(1);
endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: memory-mapped pattern engine, sole writer of the LED register
//   clk, rst (async active-low)
//   addr/wdata/we: CPU register writes (0 PATTERN, 1 MODE, 2 DIV, 3 STATUS ro)
//   rdata: combinational read of the register selected by addr
//   led_din/led_we: registered write port into the LED register
module led_sequencer #(
    parameter int              DIV_W       = 24,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(5_000_000),
    parameter logic [15:0]     RST_PATTERN = 16'h55aa
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    output logic [15:0] led_din,
    output logic        led_we
);
    import led_seq_pkg::*;

    logic [15:0]      pattern, cur, cur_n;
    logic [1:0]       mode;
    logic [DIV_W-1:0] div;
    state_t           state, state_n;
    logic             tick, wr_pat, wr_mode, wr_div;

    assign wr_pat  = we && addr == ADDR_PATTERN;
    assign wr_mode = we && addr == ADDR_MODE;
    assign wr_div  = we && addr == ADDR_DIV;

    // Any register write restarts the tick period, so a write always beats a tick.
    tick_prescaler #(.DIV_W(DIV_W)) u_pre (
        .clk  (clk),
        .rst  (rst),
        .div  (div),
        .clear(wr_pat || wr_mode || wr_div),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            state <= S_DIRECT;
        else
            state <= state_n;

    always_comb begin
        state_n = state;
        cur_n   = cur;
        if (wr_mode) begin
            state_n = entry_state(wdata[1:0]);
            cur_n   = pattern;
        end else if (wr_pat) begin
            state_n = entry_state(mode);
            cur_n   = wdata[15:0];
        end else if (tick) begin
            if (state == S_BLINK_ON) begin
                state_n = S_BLINK_OFF;
                cur_n   = '0;
            end else if (state == S_BLINK_OFF) begin
                state_n = S_BLINK_ON;
                cur_n   = pattern;
            end else if (state == S_ROTATE) begin
                cur_n = mode == MODE_ROTL ? {cur[14:0], cur[15]} : {cur[0], cur[15:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            pattern <= RST_PATTERN;
            mode    <= MODE_DIRECT;
            div     <= DEFAULT_DIV;
            cur     <= RST_PATTERN;
            led_din <= RST_PATTERN;
            led_we  <= 1'b0;
        end else begin
            if (wr_pat)  pattern <= wdata[15:0];
            if (wr_mode) mode    <= wdata[1:0];
            if (wr_div)  div     <= wdata[DIV_W-1:0];
            cur     <= cur_n;
            led_din <= cur_n;
            led_we  <= cur_n != cur || wr_pat || wr_mode;
        end

    assign rdata = addr == ADDR_PATTERN ? {16'b0, pattern} :
                   addr == ADDR_MODE    ? {30'b0, mode} :
                   addr == ADDR_DIV     ? 32'(div) :
                                          {14'b0, state, cur};
endmodule
